// File: rtl/atm_pkg.sv
// Shared constants, state encoding and helpers for the ATM cash dispenser.
// The optional low-cash warning is enabled with ATM_LOW_CASH_WARN_EN.
package atm_pkg;

    localparam int NUM_CASSETTES = 5;

    localparam logic [6:0] DENOM_0 = 7'd50;
    localparam logic [6:0] DENOM_1 = 7'd20;
    localparam logic [6:0] DENOM_2 = 7'd10;
    localparam logic [6:0] DENOM_3 = 7'd5;
    localparam logic [6:0] DENOM_4 = 7'd1;

    localparam logic [1:0] FAULT_NONE      = 2'b00;
    localparam logic [1:0] FAULT_NO_CHANGE = 2'b01;
    localparam logic [1:0] FAULT_JAM       = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAN  = 3'd1,
        FIRE  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_e;

    // Face value of the note held in cassette idx (highest first).
    function automatic logic [6:0] denom(input logic [2:0] idx);
        case (idx)
            3'd0:    denom = DENOM_0;
            3'd1:    denom = DENOM_1;
            3'd2:    denom = DENOM_2;
            3'd3:    denom = DENOM_3;
            3'd4:    denom = DENOM_4;
            default: denom = 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/atm_cassette_counter.sv
// Inventory counter for one note cassette: load on reset/refill, saturating decrement.
// With ATM_LOW_CASH_WARN_EN defined it also raises a registered low-inventory flag.
module atm_cassette_counter
    import atm_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int INIT_NOTES = 100,
    parameter int LOW_THRESH = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             low
);

    logic [CNT_W-1:0] cnt_r;

    // Inventory register; a decrement at zero is refused so it cannot wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= CNT_W'(INIT_NOTES);
        end else if (load) begin
            cnt_r <= CNT_W'(INIT_NOTES);
        end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign count = cnt_r;

`ifdef ATM_LOW_CASH_WARN_EN
    logic low_r;

    // Warning flag follows the inventory one cycle later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            low_r <= 1'b0;
        end else begin
            low_r <= (cnt_r < CNT_W'(LOW_THRESH));
        end
    end

    assign low = low_r;
`else
    assign low = 1'b0;
`endif

endmodule

// File: rtl/atm_cash_dispenser.sv
// Plans a greedy note split against cassette inventory, then feeds notes one at a time.
// Optional low-cash flags are built only when ATM_LOW_CASH_WARN_EN is defined.
module atm_cash_dispenser
    import atm_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int INIT_NOTES  = 100,
    parameter int ACK_TIMEOUT = 64,
    parameter int LOW_THRESH  = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dispense_req,
    input  logic [6:0] dispense_amount,
    input  logic       refill,
    input  logic       note_ack,
    output logic       busy,
    output logic [2:0] note_sel,
    output logic       note_fire,
    output logic       dispense_done,
    output logic       dispense_fault,
    output logic [1:0] fault_code,
    output logic [4:0] low_cash
);

    localparam int         TMR_W    = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [2:0] LAST_IDX = 3'(NUM_CASSETTES - 1);

    state_e                   state_r, state_s;
    logic [6:0]               remaining_r, remaining_s;
    logic [2:0]               idx_r, idx_s;
    logic [CNT_W-1:0]         plan_r [NUM_CASSETTES];
    logic [CNT_W-1:0]         plan_s [NUM_CASSETTES];
    logic [TMR_W-1:0]         timer_r, timer_s;
    logic [CNT_W-1:0]         inv_s  [NUM_CASSETTES];
    logic [NUM_CASSETTES-1:0] dec_s;
    logic                     load_s;
    logic                     fire_s;
    logic [1:0]               fault_code_s;

    for (genvar g = 0; g < NUM_CASSETTES; g++) begin : g_cassette
        atm_cassette_counter #(
            .CNT_W      (CNT_W),
            .INIT_NOTES (INIT_NOTES),
            .LOW_THRESH (LOW_THRESH)
        ) u_counter (
            .clock (clock),
            .reset (reset),
            .load  (load_s),
            .dec   (dec_s[g]),
            .count (inv_s[g]),
            .low   (low_cash[g])
        );
    end

    // Next-state logic: planning walks cassettes high to low, firing replays the plan.
    always_comb begin
        state_s      = state_r;
        remaining_s  = remaining_r;
        idx_s        = idx_r;
        plan_s       = plan_r;
        timer_s      = timer_r;
        dec_s        = {NUM_CASSETTES{1'b0}};
        load_s       = 1'b0;
        fire_s       = 1'b0;
        fault_code_s = fault_code;

        case (state_r)
            IDLE: begin
                if (dispense_req) begin
                    remaining_s  = dispense_amount;
                    for (int i = 0; i < NUM_CASSETTES; i++) begin
                        plan_s[i] = {CNT_W{1'b0}};
                    end
                    idx_s        = 3'd0;
                    fault_code_s = FAULT_NONE;
                    state_s      = PLAN;
                end else if (refill) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            PLAN: begin
                if ((remaining_r >= denom(idx_r)) && (plan_r[idx_r] < inv_s[idx_r])) begin
                    plan_s[idx_r] = plan_r[idx_r] + CNT_W'(1);
                    remaining_s   = remaining_r - denom(idx_r);
                end else if (idx_r < LAST_IDX) begin
                    idx_s = idx_r + 3'd1;
                end else if (remaining_r == 7'd0) begin
                    idx_s   = 3'd0;
                    state_s = FIRE;
                end else begin
                    fault_code_s = FAULT_NO_CHANGE;
                    state_s      = FAULT;
                end
            end
            FIRE: begin
                if (plan_r[idx_r] != {CNT_W{1'b0}}) begin
                    fire_s  = 1'b1;
                    timer_s = {TMR_W{1'b0}};
                    state_s = WAIT;
                end else if (idx_r < LAST_IDX) begin
                    idx_s = idx_r + 3'd1;
                end else begin
                    state_s = DONE;
                end
            end
            WAIT: begin
                // An ack arriving on the last timer cycle still counts as delivered.
                if (note_ack) begin
                    dec_s[idx_r]  = 1'b1;
                    plan_s[idx_r] = plan_r[idx_r] - CNT_W'(1);
                    state_s       = FIRE;
                end else if (timer_r == TMR_W'(ACK_TIMEOUT - 1)) begin
                    fault_code_s = FAULT_JAM;
                    state_s      = FAULT;
                end else begin
                    timer_s = timer_r + TMR_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            FAULT: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Sequencer state, working amount, cursor, plan and ack timer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            remaining_r <= 7'd0;
            idx_r       <= 3'd0;
            timer_r     <= {TMR_W{1'b0}};
            for (int i = 0; i < NUM_CASSETTES; i++) begin
                plan_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            state_r     <= state_s;
            remaining_r <= remaining_s;
            idx_r       <= idx_s;
            timer_r     <= timer_s;
            plan_r      <= plan_s;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy           <= 1'b0;
            note_fire      <= 1'b0;
            note_sel       <= 3'd0;
            dispense_done  <= 1'b0;
            dispense_fault <= 1'b0;
            fault_code     <= FAULT_NONE;
        end else begin
            busy           <= (state_s != IDLE);
            note_fire      <= fire_s;
            note_sel       <= fire_s ? idx_r : 3'd0;
            dispense_done  <= (state_s == DONE);
            dispense_fault <= (state_s == FAULT);
            fault_code     <= fault_code_s;
        end
    end

endmodule
